serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - bin, LSB first, one bit per clock through a single
// full-subtractor cell and a borrow flip-flop. Define SERIAL_SUB_OVF_EN to add the ovf output.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready and out_valid are registers updated only with state, so neither depends on inputs.

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] r_sh_q;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;

  logic             diff_d;
  logic             borrow_d;
  logic [WIDTH-1:0] r_sh_d;

`ifdef SERIAL_SUB_OVF_EN
  logic sign_a_q;
  logic sign_b_q;
  logic ovf_q;
`endif

  // One full-subtractor cell; the new diff bit enters at the MSB so that after WIDTH
  // shifts the first (LSB) diff bit has reached bit 0.
  always_comb begin
    diff_d   = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
    borrow_d = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
    r_sh_d   = {diff_d, {(WIDTH-1){1'b0}}} | (r_sh_q >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      r_sh_q      <= '0;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      d_q         <= '0;
      bout_q      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            borrow_q   <= bin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            sign_a_q   <= a[WIDTH-1];
            sign_b_q   <= b[WIDTH-1];
`endif
          end
        end

        RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          borrow_q <= borrow_d;
          r_sh_q   <= r_sh_d;
          if (cnt_q == CNT_LAST) begin
            // Terminal bit: publish the result; cnt is not advanced past WIDTH-1.
            d_q         <= r_sh_d;
            bout_q      <= borrow_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q       <= (sign_a_q ^ sign_b_q) & (sign_a_q ^ diff_d);
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign d         = d_q;
  assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
